display_timings_480p: RTL

Display timing generator for 640x480 60 Hz, clocked by the 25.2 MHz pixel clock from the 480p PLL stage. Produces the current screen position plus hsync, vsync, data-enable and line/frame strobes that drive the TMDS encoders and all pixel-generation logic, including the Mandelbrot renderer's framebuffer readout. Reset is held until the pixel clock is locked, so timing starts cleanly at the top-left pixel of a fresh frame.

---
 rtl/display_pkg.sv | 21 ++
 rtl/display_axis.sv | 60 ++++++
 rtl/display_timings_480p.sv | 103 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared 640x480 60 Hz timing constants and sync polarity type for the display pipeline.
package display_pkg;

  typedef enum logic {
    ACTIVE_LOW  = 1'b0,
    ACTIVE_HIGH = 1'b1
  } sync_pol_t;

  localparam int H_RES_480P   = 640;
  localparam int H_FP_480P    = 16;
  localparam int H_SYNC_480P  = 96;
  localparam int H_BP_480P    = 48;
  localparam int H_TOTAL_480P = H_RES_480P + H_FP_480P + H_SYNC_480P + H_BP_480P;

  localparam int V_RES_480P   = 480;
  localparam int V_FP_480P    = 10;
  localparam int V_SYNC_480P  = 2;
  localparam int V_BP_480P    = 33;
  localparam int V_TOTAL_480P = V_RES_480P + V_FP_480P + V_SYNC_480P + V_BP_480P;

endpackage

// File: rtl/display_axis.sv
// One timing axis: position counter with advance enable and wrap, plus sync-window and
// active-area decode taken from the next-state position so they line up with pos.
module display_axis
  import display_pkg::*;
#(
  parameter int        W    = 10,
  parameter int        RES  = H_RES_480P,
  parameter int        FP   = H_FP_480P,
  parameter int        SYNC = H_SYNC_480P,
  parameter int        BP   = H_BP_480P,
  parameter sync_pol_t POL  = ACTIVE_LOW
) (
  input  logic         clk_pix,
  input  logic         rst_pix_n,
  input  logic         en,
  output logic [W-1:0] pos,
  output logic         wrap,
  output logic         sync,
  output logic         active_next,
  output logic         zero_next
);

  localparam int TOTAL = RES + FP + SYNC + BP;

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] RES_W    = W'(RES);
  localparam logic [W-1:0] SYNC_BEG = W'(RES + FP);
  localparam logic [W-1:0] SYNC_END = W'(RES + FP + SYNC - 1);

  localparam logic SYNC_ON  = logic'(POL);
  localparam logic SYNC_OFF = ~logic'(POL);

  logic [W-1:0] pos_next;
  logic         sync_next;

  assign wrap = en && (pos == LAST);

  // NOTE: default assignment first so every path drives pos_next; no latch is inferred.
  always_comb begin
    pos_next = pos;
    if (en) pos_next = wrap ? '0 : pos + 1'b1;
  end

  assign active_next = (pos_next < RES_W);
  assign zero_next   = (pos_next == '0);
  assign sync_next   = ((pos_next >= SYNC_BEG) && (pos_next <= SYNC_END)) ? SYNC_ON : SYNC_OFF;

  // Reset parks the counter on its last value so the first enabled edge lands on 0.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      pos  <= LAST;
      sync <= SYNC_OFF;
    end else begin
      pos  <= pos_next;
      sync <= sync_next;
    end
  end

endmodule

// File: rtl/display_timings_480p.sv
// 640x480 60 Hz display timing generator: position, syncs, data enable, line/frame strobes.
// Optional 16-bit frame counter enabled by defining DISPLAY_FRAME_COUNT_EN.
module display_timings_480p
  import display_pkg::*;
#(
  parameter int        CORDW  = 10,
  parameter int        H_RES  = H_RES_480P,
  parameter int        H_FP   = H_FP_480P,
  parameter int        H_SYNC = H_SYNC_480P,
  parameter int        H_BP   = H_BP_480P,
  parameter int        V_RES  = V_RES_480P,
  parameter int        V_FP   = V_FP_480P,
  parameter int        V_SYNC = V_SYNC_480P,
  parameter int        V_BP   = V_BP_480P,
  parameter sync_pol_t H_POL  = ACTIVE_LOW,
  parameter sync_pol_t V_POL  = ACTIVE_LOW
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
`ifdef DISPLAY_FRAME_COUNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  logic h_wrap;
  logic h_active_next;
  logic h_zero_next;
  logic v_wrap;
  logic v_active_next;
  logic v_zero_next;

  display_axis #(
    .W    (CORDW),
    .RES  (H_RES),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP),
    .POL  (H_POL)
  ) u_h_axis (
    .clk_pix     (clk_pix),
    .rst_pix_n   (rst_pix_n),
    .en          (1'b1),
    .pos         (sx),
    .wrap        (h_wrap),
    .sync        (hsync),
    .active_next (h_active_next),
    .zero_next   (h_zero_next)
  );

  // The vertical axis only moves on the horizontal wrap.
  display_axis #(
    .W    (CORDW),
    .RES  (V_RES),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP),
    .POL  (V_POL)
  ) u_v_axis (
    .clk_pix     (clk_pix),
    .rst_pix_n   (rst_pix_n),
    .en          (h_wrap),
    .pos         (sy),
    .wrap        (v_wrap),
    .sync        (vsync),
    .active_next (v_active_next),
    .zero_next   (v_zero_next)
  );

  logic frame_next;
  assign frame_next = h_zero_next && v_zero_next;

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      de    <= 1'b0;
      line  <= 1'b0;
      frame <= 1'b0;
    end else begin
      de    <= h_active_next && v_active_next;
      line  <= h_zero_next;
      frame <= frame_next;
    end
  end

`ifdef DISPLAY_FRAME_COUNT_EN
  // Starts at all-ones so the first frame after reset reads 0; wraps freely.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n)     frame_cnt <= 16'hFFFF;
    else if (frame_next) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule
